cpu_ctrl_fsm: RTL
=================

# cpu_ctrl_fsm

Multi-cycle control unit for the 16-bit, 16-opcode CPU. Sequences fetch, decode, execute, memory and write-back, driving every enable and mux select of the register file, ALU, PC, IR and memory port. Owns the CMP flag register and resolves conditional branches. Sits inside `CPU`, between the IR opcode field and the datapath.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; 0 = reset
- `ir_op`  in  4  IR[15:12]; valid from DECODE onward
- `alu_z`  in  1  ALU result == 0
- `alu_n`  in  1  ALU result sign bit, meaningful for SUB
- `mem_ready`  in  1  memory access complete (used only with `CPU_CTRL_MEM_WAIT_EN`)
- `pc_we`  out  1  PC load
- `pc_sel`  out  1  0 = PC+1, 1 = branch target (IR address field)
- `ir_we`  out  1  IR load from memory data
- `mem_re`  out  1  memory read strobe
- `mem_we`  out  1  memory write strobe
- `addr_sel`  out  1  memory address: 0 = PC, 1 = IR address field
- `reg_we`  out  1  register file write
- `reg_src`  out  2  write data: 0 ALU, 1 memory, 2 immediate (MOV), 3 source register (MVR)
- `alu_op`  out  3  0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 PASS
- `halted`  out  1  CPU stopped on HALT
- `state`  out  3  current state, for debug

## Operation
- Opcodes: 0 HALT, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6 LD, 7 STR, 8 MOV, 9 MVR, A CMP, B B, C BEQ, D BNE, E BLT, F BGT.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Register for state and flags; all outputs combinational from state, `ir_op`, flags and `mem_ready`.
- Outputs default to 0, `alu_op` defaults to PASS.
- FETCH: `mem_re`=1, `addr_sel`=0. On access complete: `ir_we`=1, `pc_we`=1, `pc_sel`=0, go to DECODE.
- DECODE: HALT → HALT. Any other opcode → EXEC.
- EXEC:
  - AND..SUB: `alu_op` set per op, go to WB.
  - MOV, MVR: go to WB.
  - CMP: `alu_op`=SUB. Latch Z=`alu_z`, LT=`alu_n`, GT=!`alu_z`&!`alu_n`. Go to FETCH.
  - B: always taken. BEQ taken when Z. BNE taken when !Z. BLT taken when LT. BGT taken when GT.
  - Branch taken: `pc_we`=1, `pc_sel`=1. Either way, go to FETCH.
  - LD, STR: go to MEM.
- MEM: `addr_sel`=1. LD drives `mem_re`=1; on completion go to WB. STR drives `mem_we`=1; on completion go to FETCH.
- WB: `reg_we`=1. `reg_src` = ALU for AND..SUB, memory for LD, immediate for MOV, register for MVR. Go to FETCH.
- HALT: `halted`=1, all strobes 0. Stays in HALT until reset.
- Flags change only on CMP. Arithmetic ops do not touch them.
- Reset asserted: state=FETCH, flags Z/LT/GT=0, `halted`=0. Output values follow from FETCH, so `mem_re`=1 and `addr_sel`=0 during and after reset.
- Reset mid-access: strobes for the aborted access drop immediately; memory side effects already committed are not undone.

## Timing
- Zero wait states; cycles include fetch:
  - ALU ops, MOV, MVR, LD-less paths through WB: 4 cycles.
  - CMP and all branches: 3 cycles.
  - LD: 5 cycles.
  - STR: 4 cycles.
- Each wait cycle adds 1 cycle to FETCH or MEM. Strobes stay asserted, with address select held, until `mem_ready`=1 is sampled.
- `mem_we` is high for exactly one accepted cycle per STR.
- Branch target and PC+1 never both load in one instruction: taken branches overwrite the PC in EXEC, after the FETCH increment.

## Configuration
- `CPU_CTRL_MEM_WAIT_EN` defined: FETCH and MEM advance only when `mem_ready`=1.
- Not defined: `mem_ready` is ignored. Every access completes in one cycle, matching the current single-cycle block memory.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams;
  - state encodings;
  - `alu_op` codes;
  - `reg_src` codes.
  - The datapath and the testbench use the same package.
- One sub-module, `cpu_branch_eval`: flag register (Z/LT/GT, write enable, async active-low reset) plus the taken decode. Output is `taken` for the current `ir_op`.

## Test plan
- Reset low for 3 cycles, then high → `state`=0, `mem_re`=1, flags 0. First `ir_we` pulse at cycle 1.
- ADD (op 4), zero wait → `ir_we` at c1, `alu_op`=3 at c3, `reg_we` with `reg_src`=0 at c4, back to FETCH at c5.
- CMP with `alu_z`=0, `alu_n`=1, then BLT → LT latched, BLT loads `pc_sel`=1. A following BEQ does not pulse `pc_we` in EXEC.
- LD with the macro on and `mem_ready` low for 2 cycles in MEM → `mem_re`/`addr_sel`=1 held 3 cycles, then `reg_src`=1 write; total 7 cycles.
- STR → exactly one accepted `mem_we` cycle with `addr_sel`=1, no `reg_we`.
- HALT (op 0) → `halted`=1 from cycle 3, no strobes for 20 cycles. Reset pulse mid-HALT returns to FETCH with flags cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-opcode CPU: opcodes, control states, ALU codes and
// register write-back source selects, used by control, datapath and bench alike.
package cpu_pkg;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_MVR  = 4'h9;
  localparam logic [3:0] OP_CMP  = 4'hA;
  localparam logic [3:0] OP_B    = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_BLT  = 4'hE;
  localparam logic [3:0] OP_BGT  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_ADD  = 3'd3;
  localparam logic [2:0] ALU_SUB  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_IMM = 2'd2;
  localparam logic [1:0] SRC_REG = 2'd3;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_AND) && (op <= OP_SUB);
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [2:0] code;
    case (op)
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_XOR:  code = ALU_XOR;
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the control FSM (master) and the CPU datapath/memory port (slave).
interface cpu_ctrl_fsm_if;

  logic [3:0] ir_op;
  logic       alu_z;
  logic       alu_n;
  logic       mem_ready;

  logic       pc_we;
  logic       pc_sel;
  logic       ir_we;
  logic       mem_re;
  logic       mem_we;
  logic       addr_sel;
  logic       reg_we;
  logic [1:0] reg_src;
  logic [2:0] alu_op;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  ir_op, alu_z, alu_n, mem_ready,
    output pc_we, pc_sel, ir_we, mem_re, mem_we, addr_sel,
    output reg_we, reg_src, alu_op, halted, state
  );

  modport slave (
    output ir_op, alu_z, alu_n, mem_ready,
    input  pc_we, pc_sel, ir_we, mem_re, mem_we, addr_sel,
    input  reg_we, reg_src, alu_op, halted, state
  );

endinterface

// File: rtl/cpu_branch_eval.sv
// CMP flag register (Z/LT/GT) and conditional-branch resolution for the current opcode.
// Flags load only on i_flag_we; o_taken is purely combinational from flags and opcode.
module cpu_branch_eval
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flag_we,
  input  logic       i_alu_z,
  input  logic       i_alu_n,
  input  logic [3:0] i_ir_op,
  output logic       o_taken
);

  logic r_z;
  logic r_lt;
  logic r_gt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_z  <= 1'b0;
      r_lt <= 1'b0;
      r_gt <= 1'b0;
    end else if (i_flag_we) begin
      r_z  <= i_alu_z;
      r_lt <= i_alu_n;
      r_gt <= !i_alu_z && !i_alu_n;
    end
  end

  always_comb begin
    o_taken = 1'b0;
    case (i_ir_op)
      OP_B:    o_taken = 1'b1;
      OP_BEQ:  o_taken = r_z;
      OP_BNE:  o_taken = !r_z;
      OP_BLT:  o_taken = r_lt;
      OP_BGT:  o_taken = r_gt;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control: FETCH/DECODE/EXEC/MEM/WB/HALT, all outputs combinational from state.
// Define CPU_CTRL_MEM_WAIT_EN to stall FETCH and MEM on mem_ready; otherwise accesses take one cycle.
module cpu_ctrl_fsm
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cpu_ctrl_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_done;
  logic       w_flag_we;
  logic       w_taken;

  logic       w_pc_we;
  logic       w_pc_sel;
  logic       w_ir_we;
  logic       w_mem_re;
  logic       w_mem_we;
  logic       w_addr_sel;
  logic       w_reg_we;
  logic [1:0] w_reg_src;
  logic [2:0] w_alu_op;
  logic       w_halted;

`ifdef CPU_CTRL_MEM_WAIT_EN
  assign w_mem_done = bus.mem_ready;
`else
  // Single-cycle block memory: every access completes in the cycle it is issued.
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = bus.mem_ready;
  assign w_mem_done = 1'b1;
`endif

  cpu_branch_eval u_branch (
    .clk       (clk),
    .reset     (reset),
    .i_flag_we (w_flag_we),
    .i_alu_z   (bus.alu_z),
    .i_alu_n   (bus.alu_n),
    .i_ir_op   (bus.ir_op),
    .o_taken   (w_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_flag_we  = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 1'b0;
    w_ir_we    = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_addr_sel = 1'b0;
    w_reg_we   = 1'b0;
    w_reg_src  = SRC_ALU;
    w_alu_op   = ALU_PASS;
    w_halted   = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_mem_re   = 1'b1;
        w_addr_sel = 1'b0;
        if (w_mem_done) begin
          w_ir_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_sel = 1'b0;
          w_next   = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_next = (bus.ir_op == OP_HALT) ? ST_HALT : ST_EXEC;
      end

      ST_EXEC: begin
        w_next = ST_FETCH;
        if (is_alu_op(bus.ir_op)) begin
          w_alu_op = alu_code(bus.ir_op);
          w_next   = ST_WB;
        end else begin
          case (bus.ir_op)
            OP_MOV, OP_MVR: w_next = ST_WB;
            OP_LD, OP_STR:  w_next = ST_MEM;
            OP_CMP: begin
              w_alu_op  = ALU_SUB;
              w_flag_we = 1'b1;
            end
            default: begin
              // Taken branch overwrites the PC+1 already loaded during FETCH.
              if (w_taken) begin
                w_pc_we  = 1'b1;
                w_pc_sel = 1'b1;
              end
            end
          endcase
        end
      end

      ST_MEM: begin
        w_addr_sel = 1'b1;
        if (bus.ir_op == OP_LD) begin
          w_mem_re = 1'b1;
          if (w_mem_done) begin
            w_next = ST_WB;
          end
        end else begin
          w_mem_we = 1'b1;
          if (w_mem_done) begin
            w_next = ST_FETCH;
          end
        end
      end

      ST_WB: begin
        w_reg_we = 1'b1;
        case (bus.ir_op)
          OP_LD:   w_reg_src = SRC_MEM;
          OP_MOV:  w_reg_src = SRC_IMM;
          OP_MVR:  w_reg_src = SRC_REG;
          default: w_reg_src = SRC_ALU;
        endcase
        w_next = ST_FETCH;
      end

      ST_HALT: begin
        w_halted = 1'b1;
        w_next   = ST_HALT;
      end

      default: begin
        w_next = ST_FETCH;
      end
    endcase
  end

  assign bus.pc_we    = w_pc_we;
  assign bus.pc_sel   = w_pc_sel;
  assign bus.ir_we    = w_ir_we;
  assign bus.mem_re   = w_mem_re;
  assign bus.mem_we   = w_mem_we;
  assign bus.addr_sel = w_addr_sel;
  assign bus.reg_we   = w_reg_we;
  assign bus.reg_src  = w_reg_src;
  assign bus.alu_op   = w_alu_op;
  assign bus.halted   = w_halted;
  assign bus.state    = r_state;

endmodule
